// File: rtl/round_key_xor_stream_pkg.sv
// Shared AES definitions for the round-key XOR stream: byte/word types,
// standard key-schedule sizes and the key-store word-address helper.
package round_key_xor_stream_pkg;

   typedef logic [7:0]  aes_byte_t;
   typedef logic [31:0] aes_word_t;

   // State width in 32-bit columns for every AES variant
   localparam int NB_DEFAULT = 4;

   // Last round index for each AES key size
   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   // Round keys are stored round-major: one NB-word block per round
   function automatic int unsigned word_addr(input int unsigned round,
                                             input int unsigned col,
                                             input int unsigned nb);
      return round * nb + col;
   endfunction

endpackage

// File: rtl/round_key_store.sv
// Round-key store: (NR+1)*NB words of 32 bits, one write port and CPB
// combinational read ports. A read of a word written in the same cycle
// returns the old contents; the new word is visible from the next cycle.
// Writes beyond the last round key are dropped; such reads return zero.
module round_key_store
   import round_key_xor_stream_pkg::*;
#(
   parameter int NB  = NB_DEFAULT,
   parameter int CPB = 1,
   parameter int NR  = NR_AES128,
   parameter int KA  = $clog2((NR + 1) * NB)
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [KA-1:0]          wr_addr,
   input  aes_word_t              wr_data,
   input  logic [CPB-1:0][KA-1:0] rd_addr,
   output aes_word_t [CPB-1:0]    rd_data
);

   localparam int unsigned DEPTH = (NR + 1) * NB;

   aes_word_t mem [DEPTH];

   // Key word write; out-of-range addresses are ignored
   // NOTE: the key array has no reset -- it is always loaded before use, and
   // leaving it unreset lets synthesis map it onto plain flops or LUT RAM.
   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // One asynchronous read per lane of the beat
   // NOTE: assigning the whole output a default before the loop keeps every
   // bit driven on every path, so no latch is inferred.
   always_comb begin
      rd_data = '0;
      for (int j = 0; j < CPB; j++) begin
         if (32'(rd_addr[j]) < DEPTH) begin
            rd_data[j] = mem[rd_addr[j]];
         end
      end
   end

endmodule

// File: rtl/round_key_xor_stream.sv
// Column-serial AddRoundKey stage with valid/ready handshake.
// Each AES state arrives as NB/CPB beats of CPB columns (lowest column in the
// MSBs). The round index is taken on the first beat of a state and held for
// the rest; the beat is XORed with that round's key columns and registered.
// Rounds above NR pass the data through unchanged and flag out_err.
// Optional feature macro: ROUND_KEY_XOR_PARITY_EN adds per-byte even parity
// (in_par checked against in_data, out_par generated from out_data).
module round_key_xor_stream
   import round_key_xor_stream_pkg::*;
#(
   parameter  int NB    = NB_DEFAULT,
   parameter  int CPB   = 1,
   parameter  int NR    = NR_AES128,
   localparam int W     = 32 * CPB,
   localparam int BEATS = NB / CPB,
   localparam int KA    = $clog2((NR + 1) * NB),
   localparam int RW    = $clog2(NR + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_wr_en,
   input  logic [KA-1:0] key_wr_addr,
   input  aes_word_t     key_wr_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [RW-1:0] in_round,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_last,
   output logic          out_err
`ifdef ROUND_KEY_XOR_PARITY_EN
   ,
   input  logic [4*CPB-1:0] in_par,
   output logic [4*CPB-1:0] out_par
`endif
);

   localparam int            CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [RW-1:0] NR_IDX   = RW'(NR);
   localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

   logic [CW-1:0]          beat_q;
   logic [RW-1:0]          round_q;
   logic                   accept;
   logic [RW-1:0]          cur_round;
   logic                   round_bad;
   logic                   par_err;
   logic [CPB-1:0][KA-1:0] rd_addr;
   aes_word_t [CPB-1:0]    key_word;
   logic [W-1:0]           xor_data;

   // Single output register: a new beat can enter whenever the slot drains
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   // First beat of a state uses in_round directly; later beats use the latch
   assign cur_round = (beat_q == '0) ? in_round : round_q;
   assign round_bad = cur_round > NR_IDX;

   round_key_store #(
      .NB  (NB),
      .CPB (CPB),
      .NR  (NR),
      .KA  (KA)
   ) u_store (
      .clk     (clk),
      .wr_en   (key_wr_en),
      .wr_addr (key_wr_addr),
      .wr_data (key_wr_data),
      .rd_addr (rd_addr),
      .rd_data (key_word)
   );

   // Key addresses and XOR lanes for the beat currently offered
   always_comb begin
      rd_addr  = '0;
      xor_data = '0;
      for (int j = 0; j < CPB; j++) begin
         rd_addr[j] = KA'(word_addr(32'(cur_round), 32'(beat_q) * CPB + j, NB));
         xor_data[W-1-32*j -: 32] = in_data[W-1-32*j -: 32]
                                  ^ (round_bad ? 32'h0 : key_word[j]);
      end
   end

`ifdef ROUND_KEY_XOR_PARITY_EN
   logic [4*CPB-1:0] in_par_calc;
   logic [4*CPB-1:0] out_par_d;

   // Per-byte even parity of the incoming and outgoing beat
   always_comb begin
      in_par_calc = '0;
      out_par_d   = '0;
      for (int i = 0; i < 4 * CPB; i++) begin
         in_par_calc[i] = ^in_data[8*i +: 8];
         out_par_d[i]   = ^xor_data[8*i +: 8];
      end
   end

   assign par_err = (in_par_calc != in_par);

   // Parity is registered alongside out_data
   always_ff @(posedge clk) begin
      if (rst) begin
         out_par <= '0;
      end else if (accept) begin
         out_par <= out_par_d;
      end
   end
`else
   assign par_err = 1'b0;
`endif

   // Output register, beat counter and round latch
   // NOTE: non-blocking assignments here so every flop samples pre-edge values
   // and the order of statements inside the block does not matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
         beat_q    <= '0;
         round_q   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= xor_data;
         out_last  <= (beat_q == LAST_IDX);
         out_err   <= round_bad || par_err;
         beat_q    <= (beat_q == LAST_IDX) ? '0 : beat_q + 1'b1;
         if (beat_q == '0) begin
            round_q <= in_round;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_round_key_xor_stream.sv
// Bench for round_key_xor_stream: a default instance (NB=4, CPB=1, NR=10)
// driven by a vector table and hand-written corner sequences, and a CPB=2
// instance driven by random traffic/backpressure against a state-level model.
module tb_round_key_xor_stream;
   import round_key_xor_stream_pkg::*;

   localparam int NB = 4;
   localparam int NR = 10;
   localparam int KA = 6;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          key_wr_en = 1'b0;
   logic [KA-1:0] key_wr_addr = '0;
   aes_word_t     key_wr_data = '0;

   // Instance A: CPB=1
   logic          a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
   logic [31:0]   a_in_data = '0, a_out_data;
   logic [RW-1:0] a_in_round = '0;
   logic          a_out_last, a_out_err;

   // Instance B: CPB=2
   logic          b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
   logic [63:0]   b_in_data = '0, b_out_data;
   logic [RW-1:0] b_in_round = '0;
   logic          b_out_last, b_out_err;

   function automatic logic [3:0] par32(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   function automatic logic [7:0] par64(input logic [63:0] d);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

`ifdef ROUND_KEY_XOR_PARITY_EN
   logic [3:0] a_par_flip = '0;
   logic [3:0] a_in_par, a_out_par;
   logic [7:0] b_in_par, b_out_par;
   assign a_in_par = par32(a_in_data) ^ a_par_flip;
   assign b_in_par = par64(b_in_data);
`endif

   round_key_xor_stream #(.NB(NB), .CPB(1), .NR(NR)) dut_a (
      .clk(clk), .rst(rst),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_round(a_in_round),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last), .out_err(a_out_err)
`ifdef ROUND_KEY_XOR_PARITY_EN
      , .in_par(a_in_par), .out_par(a_out_par)
`endif
   );

   round_key_xor_stream #(.NB(NB), .CPB(2), .NR(NR)) dut_b (
      .clk(clk), .rst(rst),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_round(b_in_round),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .out_err(b_out_err)
`ifdef ROUND_KEY_XOR_PARITY_EN
      , .in_par(b_in_par), .out_par(b_out_par)
`endif
   );

   // Reference key schedule as written by the bench
   aes_word_t keys [(NR+1)*NB];
   aes_word_t fips_key0  [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
   aes_word_t fips_key1  [4] = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
   aes_word_t fips_state [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key_write(input int addr, input aes_word_t data);
      key_wr_en   = 1'b1;
      key_wr_addr = KA'(addr);
      key_wr_data = data;
      step();
      key_wr_en = 1'b0;
      if (addr < (NR+1)*NB) keys[addr] = data;
   endtask

   // Expected output column: state column XOR round key column (zero key if round invalid)
   function automatic logic [31:0] ref_word(input logic [127:0] st, input int rnd, input int col);
      logic [31:0] k;
      k = 32'h0;
      if (rnd <= NR) k = keys[rnd*NB + col];
      return st[127-32*col -: 32] ^ k;
   endfunction

   typedef struct {
      logic [31:0]   data;
      logic [RW-1:0] round;
      logic [31:0]   exp_data;
      logic          exp_last;
      logic          exp_err;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // FIPS-197 state, round 0 (junk in_round on later beats exercises the latch)
      tbl[0]  = '{32'h3243f6a8, 4'd0,  32'h193de3be, 1'b0, 1'b0};
      tbl[1]  = '{32'h885a308d, 4'd3,  32'ha0f4e22b, 1'b0, 1'b0};
      tbl[2]  = '{32'h313198a2, 4'd3,  32'h9ac68d2a, 1'b0, 1'b0};
      tbl[3]  = '{32'he0370734, 4'd3,  32'he9f84808, 1'b1, 1'b0};
      // Invalid round 11: pass-through with out_err on every beat
      tbl[4]  = '{32'hdeadbeef, 4'd11, 32'hdeadbeef, 1'b0, 1'b1};
      tbl[5]  = '{32'hdeadbeef, 4'd0,  32'hdeadbeef, 1'b0, 1'b1};
      tbl[6]  = '{32'hdeadbeef, 4'd0,  32'hdeadbeef, 1'b0, 1'b1};
      tbl[7]  = '{32'hdeadbeef, 4'd0,  32'hdeadbeef, 1'b1, 1'b1};
      // Round 1 on a zero state exposes the round-1 key words
      tbl[8]  = '{32'h0, 4'd1,  32'ha0fafe17, 1'b0, 1'b0};
      tbl[9]  = '{32'h0, 4'd15, 32'h88542cb1, 1'b0, 1'b0};
      tbl[10] = '{32'h0, 4'd15, 32'h23a33939, 1'b0, 1'b0};
      tbl[11] = '{32'h0, 4'd15, 32'h2a6c7605, 1'b1, 1'b0};

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data",  a_out_data,  0);
      check("rst_out_last",  a_out_last,  0);
      check("rst_out_err",   a_out_err,   0);
      check("rst_in_ready",  a_in_ready,  1);
      rst = 1'b0;

      // Load the key store: FIPS rounds 0 and 1, random for the rest
      for (int a = 0; a < (NR+1)*NB; a++) begin
         if (a < 4)      key_write(a, fips_key0[a]);
         else if (a < 8) key_write(a, fips_key1[a-4]);
         else            key_write(a, $urandom);
      end

      // Table-driven back-to-back beats
      check("lat_idle", a_out_valid, 0);
      for (int i = 0; i < 12; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = tbl[i].data;
         a_in_round = tbl[i].round;
         step();
         check($sformatf("tbl%0d_valid", i), a_out_valid, 1);
         check($sformatf("tbl%0d_data", i),  a_out_data,  tbl[i].exp_data);
         check($sformatf("tbl%0d_last", i),  a_out_last,  tbl[i].exp_last);
         check($sformatf("tbl%0d_err", i),   a_out_err,   tbl[i].exp_err);
      end
      a_in_valid = 1'b0;
      step();
      check("tbl_drain_valid", a_out_valid, 0);

      // Key write to address 0 in the same cycle as beat 0 of round 0
      key_wr_en = 1'b1; key_wr_addr = '0; key_wr_data = 32'h11111111;
      a_in_valid = 1'b1; a_in_data = '0; a_in_round = 4'd0;
      step();
      key_wr_en = 1'b0;
      keys[0] = 32'h11111111;
      check("coll_old_key", a_out_data, 32'h2b7e1516);
      for (int b = 1; b < 4; b++) begin
         a_in_round = 4'd9;
         step();
         check($sformatf("coll_b%0d", b), a_out_data, keys[b]);
      end
      a_in_round = 4'd0;
      step();
      check("coll_new_key", a_out_data, 32'h11111111);
      for (int b = 1; b < 4; b++) begin
         a_in_round = 4'd9;
         step();
      end
      check("coll_state_last", a_out_last, 1);

      // Reset after two beats of a round-1 state
      a_in_data = '0; a_in_round = 4'd1;
      step();
      a_in_round = 4'd9;
      step();
      check("mid_b1_data", a_out_data, 32'h88542cb1);
      a_in_valid = 1'b0;
      rst = 1'b1;
      step();
      check("mid_rst_valid", a_out_valid, 0);
      check("mid_rst_data",  a_out_data,  0);
      rst = 1'b0;
      a_in_valid = 1'b1; a_in_round = 4'd0;
      step();
      check("post_rst_b0_data", a_out_data, keys[0]);
      check("post_rst_b0_last", a_out_last, 0);
      for (int b = 1; b < 4; b++) begin
         a_in_round = 4'd7;
         step();
         check($sformatf("post_rst_b%0d_data", b), a_out_data, keys[b]);
         check($sformatf("post_rst_b%0d_last", b), a_out_last, b == 3);
      end
      a_in_valid = 1'b0;
      step();

`ifdef ROUND_KEY_XOR_PARITY_EN
      // Parity: one flipped in_par bit on beat 1 only
      for (int b = 0; b < 4; b++) begin
         logic [31:0] exp_d;
         a_in_valid = 1'b1;
         a_in_data  = fips_state[b];
         a_in_round = 4'd0;
         a_par_flip = (b == 1) ? 4'b0010 : 4'b0000;
         exp_d = fips_state[b] ^ keys[b];
         step();
         check($sformatf("par_b%0d_data", b), a_out_data, exp_d);
         check($sformatf("par_b%0d_err", b),  a_out_err,  b == 1);
         check($sformatf("par_b%0d_par", b),  a_out_par,  par32(exp_d));
      end
      a_in_valid = 1'b0;
      a_par_flip = '0;
      step();
`endif

      // Random traffic on CPB=2 with backpressure (first out_ready pattern 1,0,0,1)
      begin
         logic [127:0]  st;
         logic [RW-1:0] rnd;
         int            beat;
         logic          mv, ml, me, exp_rdy, fire_in, nl, ne;
         logic [63:0]   md, nd;
         logic          pat [4];
         int            n_in, n_out;
         pat = '{1'b1, 1'b0, 1'b0, 1'b1};
         st = {$urandom, $urandom, $urandom, $urandom};
         rnd = 4'($urandom_range(0, 13));
         beat = 0; mv = 1'b0; md = '0; ml = 1'b0; me = 1'b0;
         n_in = 0; n_out = 0;
         for (int cyc = 0; cyc < 400; cyc++) begin
            b_out_ready = (cyc < 4) ? pat[cyc] : ($urandom_range(0, 3) != 0);
            b_in_valid  = (cyc < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
            b_in_data   = st[127-64*beat -: 64];
            b_in_round  = (beat == 0) ? rnd : 4'($urandom);
            #1;
            exp_rdy = !mv || b_out_ready;
            check($sformatf("rnd%0d_in_ready", cyc), b_in_ready, exp_rdy);
            fire_in = b_in_valid && exp_rdy;
            if (mv && b_out_ready) n_out++;
            nd = {ref_word(st, int'(rnd), 2*beat), ref_word(st, int'(rnd), 2*beat + 1)};
            nl = (beat == 1);
            ne = (rnd > 4'(NR));
            @(posedge clk);
            #1;
            if (fire_in) begin
               n_in++;
               mv = 1'b1; md = nd; ml = nl; me = ne;
               if (beat == 1) begin
                  beat = 0;
                  st = {$urandom, $urandom, $urandom, $urandom};
                  rnd = 4'($urandom_range(0, 13));
               end else begin
                  beat = 1;
               end
            end else if (b_out_ready) begin
               mv = 1'b0;
            end
            check($sformatf("rnd%0d_out_valid", cyc), b_out_valid, mv);
            if (mv) begin
               check($sformatf("rnd%0d_out_data", cyc), b_out_data, md);
               check($sformatf("rnd%0d_out_last", cyc), b_out_last, ml);
               check($sformatf("rnd%0d_out_err", cyc),  b_out_err,  me);
`ifdef ROUND_KEY_XOR_PARITY_EN
               check($sformatf("rnd%0d_out_par", cyc),  b_out_par,  par64(md));
`endif
            end
         end
         b_in_valid  = 1'b0;
         b_out_ready = 1'b1;
         step();
         if (mv) n_out++;
         check("rnd_beats_in_out", 64'(n_out), 64'(n_in));
         check("rnd_drained", b_out_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
